// File: rtl/labbs_pkg.sv
// Shared definitions for the P-code sequencer: default sizes and FSM state encoding.
package labbs_pkg;

    localparam int unsigned PCODE_LEN_DEFAULT = 40920;  // chips per code period
    localparam int unsigned ACC_W_DEFAULT     = 32;     // code NCO accumulator width
    localparam int unsigned ADDR_W            = 16;     // ROM address / chip index width
    localparam int unsigned PRN_W             = 3;      // bit-lane select width
    localparam int unsigned ROM_W             = 8;      // ROM word width (one lane per PRN)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/pcode_seq_if.sv
// Load handshake and code-ROM port of the P-code sequencer.
//   load_req / load_phase : code-phase load request (level, held until ack)
//   load_ack / load_err   : one-cycle acknowledge, error flag for out-of-range phase
//   pcode_addr            : registered ROM address
//   pcode_in              : ROM data, one cycle after pcode_addr
// master: the controller/ROM side; slave: pcode_seq.
interface pcode_seq_if;
    import labbs_pkg::*;

    logic              load_req;
    logic [ADDR_W-1:0] load_phase;
    logic              load_ack;
    logic              load_err;
    logic [ADDR_W-1:0] pcode_addr;
    logic [ROM_W-1:0]  pcode_in;

    modport master (
        output load_req, load_phase, pcode_in,
        input  load_ack, load_err, pcode_addr
    );

    modport slave (
        input  load_req, load_phase, pcode_in,
        output load_ack, load_err, pcode_addr
    );

endinterface

// File: rtl/code_nco.sv
// Code NCO: phase accumulator advancing by fcw each run cycle; the carry-out is the chip strobe.
//   clk, rst : clock, async active-high reset
//   clr      : zero the accumulator (wins over run, suppresses the strobe)
//   run      : advance the accumulator this cycle
//   fcw      : frequency control word (per-clock increment)
//   strobe   : carry-out of this cycle's addition
module code_nco
    import labbs_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [ACC_W-1:0] fcw,
    output logic             strobe
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;

    // One extra bit captures the modulo-2^ACC_W wrap
    assign sum    = SUM_W'(acc) + SUM_W'(fcw);
    assign strobe = run & ~clr & sum[ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (run) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/pcode_seq.sv
// P-code chip sequencer: steps a ROM address at the code-NCO rate and qualifies the
// selected ROM bit-lane as a chip stream.
//   clk, rst   : clock, async active-high reset
//   en         : run enable (0 parks the sequencer in IDLE, holding address and NCO)
//   code_fcw   : NCO increment per clock
//   prn_sel    : ROM bit-lane select
//   bus        : load handshake + ROM address/data (pcode_seq_if.slave)
//   chip_out   : selected chip, qualified by chip_valid
//   chip_valid : one-cycle strobe, one cycle after each address presentation
//   epoch      : with chip_valid of chip 0
module pcode_seq
    import labbs_pkg::*;
#(
    parameter int unsigned PCODE_LEN = PCODE_LEN_DEFAULT,
    parameter int unsigned ACC_W     = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] code_fcw,
    input  logic [PRN_W-1:0] prn_sel,
    pcode_seq_if.slave       bus,
    output logic             chip_out,
    output logic             chip_valid,
    output logic             epoch
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PCODE_LEN - 1);

    state_t           state;
    logic             req_q;       // load_req last cycle; a load needs a 0->1 transition
    logic             addr_upd_q;  // pcode_addr was written at the last edge
    logic [PRN_W-1:0] prn_sel_q;   // lane captured with the address now on the ROM
    logic [PRN_W-1:0] chip_sel_q;  // lane of the ROM word now on pcode_in
    logic             load_take;
    logic             load_bad;
    logic             load_ok;
    logic             nco_clr;
    logic             nco_run;
    logic             strobe;
    logic             present;

    assign load_take = bus.load_req & ~req_q;
    assign load_bad  = load_take & (32'(bus.load_phase) >= PCODE_LEN);
    assign load_ok   = load_take & ~load_bad;

    // A valid load outranks a coincident strobe: clr masks it inside the NCO
    assign nco_run = en & (state == ST_RUN);
    assign nco_clr = load_ok | (en & (state == ST_PRIME));

    // ROM samples pcode_addr this cycle for a fresh address or the PRIME re-read
    assign present = (state == ST_PRIME) | addr_upd_q;

    assign chip_out = chip_valid & bus.pcode_in[chip_sel_q];

    code_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk    (clk),
        .rst    (rst),
        .clr    (nco_clr),
        .run    (nco_run),
        .fcw    (code_fcw),
        .strobe (strobe)
    );

    // Sequencer FSM, address register and output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            req_q          <= 1'b1;
            addr_upd_q     <= 1'b0;
            prn_sel_q      <= '0;
            chip_sel_q     <= '0;
            chip_valid     <= 1'b0;
            epoch          <= 1'b0;
            bus.load_ack   <= 1'b0;
            bus.load_err   <= 1'b0;
            bus.pcode_addr <= '0;
        end else begin
            req_q        <= bus.load_req;
            bus.load_ack <= load_take;
            bus.load_err <= load_bad;
            addr_upd_q   <= 1'b0;
            chip_sel_q   <= prn_sel_q;
            chip_valid   <= 1'b0;
            epoch        <= 1'b0;

            // en low sends the FSM to IDLE next cycle, where no chip may be flagged
            if (en && present) begin
                chip_valid <= 1'b1;
                epoch      <= (bus.pcode_addr == '0);
            end

            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state     <= ST_PRIME;
                        prn_sel_q <= prn_sel;
                    end
                end
                ST_PRIME: state <= en ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (load_ok) begin
                bus.pcode_addr <= bus.load_phase;
                addr_upd_q     <= 1'b1;
                prn_sel_q      <= prn_sel;
            end else if (strobe) begin
                bus.pcode_addr <= (bus.pcode_addr == LAST_ADDR) ? '0 : bus.pcode_addr + ADDR_W'(1);
                addr_upd_q     <= 1'b1;
                prn_sel_q      <= prn_sel;
            end
        end
    end

endmodule

// File: tb/tb_pcode_seq.sv
// Self-checking bench for pcode_seq: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural chip/ROM-read model.
module tb_pcode_seq;
    import labbs_pkg::*;

    localparam int LEN = 40920;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] code_fcw;
    logic [2:0]  prn_sel;
    logic        chip_out;
    logic        chip_valid;
    logic        epoch;

    pcode_seq_if bus ();

    pcode_seq #(
        .PCODE_LEN (LEN),
        .ACC_W     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code_fcw   (code_fcw),
        .prn_sel    (prn_sel),
        .bus        (bus),
        .chip_out   (chip_out),
        .chip_valid (chip_valid),
        .epoch      (epoch)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [31:0] h;
        h = {16'h0, a} * 32'h9E37_79B1;
        return h[23:16] ^ a[7:0];
    endfunction

    // One-cycle-latency code ROM
    always @(posedge clk) bus.pcode_in <= rom_fn(bus.pcode_addr);

    function automatic logic rom_bit(input int a, input int s);
        logic [7:0] w;
        w = rom_fn(16'(a));
        return w[s];
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int addr;
        int sel;
        int due;
    } read_t;

    read_t  reads[$];    // ROM reads in flight: chip expected on cycle 'due'
    int     t;
    int     m_state;
    longint m_acc;
    int     m_addr;
    int     m_sel;
    bit     m_req_prev;
    bit     m_ack;
    bit     m_err;
    bit     e_valid;
    int     e_addr;
    int     e_sel;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        reads.delete();
        m_state    = M_IDLE;
        m_acc      = 0;
        m_addr     = 0;
        m_sel      = 0;
        m_req_prev = 1'b1;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        e_valid    = 1'b0;
    endtask

    function automatic bit strobe_due();
        return (m_state == M_RUN) && en && ((m_acc + longint'(code_fcw)) >= 64'h1_0000_0000);
    endfunction

    // Advance the model across the next rising edge using the inputs now applied
    task automatic model_step();
        bit     take;
        bit     bad;
        bit     ok;
        bit     carry;
        int     nxt;
        longint s;
        take  = bus.load_req && !m_req_prev;
        bad   = take && (int'(bus.load_phase) >= LEN);
        ok    = take && !bad;
        carry = 1'b0;
        nxt   = !en ? M_IDLE : (m_state == M_IDLE) ? M_PRIME : M_RUN;
        if (m_state == M_PRIME) reads.push_back('{m_addr, m_sel, t + 1});
        if (ok) begin
            m_acc = 0;
        end else if (m_state == M_RUN && en) begin
            s     = m_acc + longint'(code_fcw);
            carry = (s >= 64'h1_0000_0000);
            m_acc = s & 64'hFFFF_FFFF;
        end else if (m_state == M_PRIME && en) begin
            m_acc = 0;
        end
        if (m_state == M_IDLE && en) m_sel = int'(prn_sel);
        if (ok) begin
            m_addr = int'(bus.load_phase);
            m_sel  = int'(prn_sel);
            reads.push_back('{m_addr, m_sel, t + 2});
        end else if (carry) begin
            m_addr = (m_addr == LEN - 1) ? 0 : m_addr + 1;
            m_sel  = int'(prn_sel);
            reads.push_back('{m_addr, m_sel, t + 2});
        end
        m_ack      = take;
        m_err      = bad;
        m_req_prev = bus.load_req;
        m_state    = nxt;
        t++;
        e_valid = 1'b0;
        while (reads.size() > 0 && reads[0].due <= t) begin
            if (reads[0].due == t && m_state != M_IDLE) begin
                e_valid = 1'b1;
                e_addr  = reads[0].addr;
                e_sel   = reads[0].sel;
            end
            void'(reads.pop_front());
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic check_outputs();
        chk("chip_valid", longint'(chip_valid), longint'(e_valid));
        chk("epoch", longint'(epoch), longint'(e_valid && e_addr == 0));
        if (e_valid) chk("chip_out", longint'(chip_out), longint'(rom_bit(e_addr, e_sel)));
        chk("load_ack", longint'(bus.load_ack), longint'(m_ack));
        chk("load_err", longint'(bus.load_err), longint'(m_err));
        chk("pcode_addr", longint'(bus.pcode_addr), longint'(m_addr));
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_chip_valid"}, longint'(chip_valid), 0);
        chk({tag, "_chip_out"}, longint'(chip_out), 0);
        chk({tag, "_epoch"}, longint'(epoch), 0);
        chk({tag, "_load_ack"}, longint'(bus.load_ack), 0);
        chk({tag, "_load_err"}, longint'(bus.load_err), 0);
        chk({tag, "_pcode_addr"}, longint'(bus.pcode_addr), 0);
    endtask

    function automatic logic [31:0] pick_fcw();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom;
            default: return $urandom_range(1, 32'h2000_0000);
        endcase
    endfunction

    function automatic logic [15:0] pick_phase();
        case ($urandom_range(0, 3))
            0:       return 16'(LEN - 3 + int'($urandom_range(0, 5)));
            1:       return 16'($urandom_range(0, 3));
            2:       return 16'hFFFF - 16'($urandom_range(0, 1));
            default: return 16'($urandom_range(0, LEN - 1));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int  nv;
        int  ne;
        int  na;
        bit  found;

        t              = 0;
        rst            = 1'b1;
        en             = 1'b0;
        code_fcw       = 32'h0;
        prn_sel        = 3'd0;
        bus.load_req   = 1'b0;
        bus.load_phase = 16'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        tick();

        // Free run at half rate, lane 3: chips at cycles 2,5,7,9,11 after enable
        en       = 1'b1;
        code_fcw = 32'h8000_0000;
        prn_sel  = 3'd3;
        nv       = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (chip_valid) nv++;
            if (i == 2) chk("prime_chip0_epoch", longint'(epoch), 1);
        end
        chk("run_valid_count", nv, 5);
        chk("run_addr_at_11", longint'(bus.pcode_addr), 4);
        repeat (20) tick();

        // Load last chip, run across the wrap: exactly one epoch
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd40919;
        tick();
        chk("load_end_ack", longint'(bus.load_ack), 1);
        chk("load_end_addr", longint'(bus.pcode_addr), 40919);
        bus.load_req = 1'b0;
        ne = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (epoch) ne++;
        end
        chk("wrap_epoch_count", ne, 1);

        // fcw=0 holds the address; out-of-range load errors and changes nothing
        code_fcw       = 32'h0;
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd500;
        tick();
        bus.load_req = 1'b0;
        tick();
        chk("fcw0_load_addr", longint'(bus.pcode_addr), 500);
        repeat (6) tick();
        chk("fcw0_hold", longint'(bus.pcode_addr), 500);
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd40920;
        tick();
        chk("bad_load_ack", longint'(bus.load_ack), 1);
        chk("bad_load_err", longint'(bus.load_err), 1);
        chk("bad_load_addr", longint'(bus.pcode_addr), 500);
        na = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.load_ack) na++;
        end
        chk("held_req_no_reack", na, 0);
        bus.load_req = 1'b0;
        tick();

        // Load in the same cycle as a strobe: no increment of the old address
        code_fcw = 32'h8000_0000;
        found    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (strobe_due()) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("strobe_found", found, 1);
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd100;
        tick();
        bus.load_req = 1'b0;
        chk("strobe_load_addr", longint'(bus.pcode_addr), 100);
        tick();
        chk("strobe_load_no_inc", longint'(bus.pcode_addr), 100);

        // Drop en at address 57, re-enable after 10 cycles: 57 re-read via PRIME
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd50;
        tick();
        bus.load_req = 1'b0;
        found        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_addr == 57 && m_state == M_RUN) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_57", found, 1);
        en = 1'b0;
        repeat (10) tick();
        chk("idle_hold_57", longint'(bus.pcode_addr), 57);
        chk("idle_no_valid", longint'(chip_valid), 0);
        en = 1'b1;
        tick();
        tick();
        chk("reprime_valid", longint'(chip_valid), 1);
        chk("reprime_addr", longint'(bus.pcode_addr), 57);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 19) != 0);
            prn_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) code_fcw = pick_fcw();
            if (bus.load_req) begin
                bus.load_req = ($urandom_range(0, 2) != 0);
            end else begin
                bus.load_req   = ($urandom_range(0, 24) == 0);
                bus.load_phase = pick_phase();
            end
            tick();
        end

        // Asynchronous reset mid-cycle during RUN with a fresh load pending
        en           = 1'b1;
        code_fcw     = 32'h4000_0000;
        bus.load_req = 1'b0;
        repeat (6) tick();
        bus.load_req   = 1'b1;
        bus.load_phase = 16'd1234;
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 2) chk("restart_epoch", longint'(epoch), 1);
        end
        bus.load_req = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
